// File: rtl/spi_aes_pkg.sv
// Shared definitions for the SPI front end of the AES core: FSM states,
// block width, frame length helper and core timeout length.
package spi_aes_pkg;

    localparam int BLOCK_W     = 128;
    localparam int TIMEOUT_CYC = 256;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RECV      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_CORE = 3'd3,
        ST_SEND      = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

    // A frame is one data block followed by the key.
    function automatic int frame_len(input int nk);
        return BLOCK_W + nk * 32;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in shift register with parallel load, shifting toward the MSB.
// Used for both the receive frame and the transmit result.
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_master,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Load takes priority so a new frame can restart the register in one edge.
    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave that collects a data block plus key, hands them to a cipher core
// and shifts the 128-bit result back out; define SPI_SLAVE_TIMEOUT_EN for a core timeout.
module spi_slave_shifter
    import spi_aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic              clk_master,
    input  logic              rst,
    input  logic              cs,
    input  logic              sdi,
    output logic              sdo,
    output logic [127:0]      core_data,
    output logic [NK*32-1:0]  core_key,
    output logic              core_start,
    input  logic              core_done,
    input  logic [127:0]      core_result,
    output logic              frame_done,
    output logic              err,
    output logic [2:0]        state
);

    localparam int         FRAME_W   = frame_len(NK);
    localparam int         KEY_W     = NK * 32;
    localparam logic [8:0] LAST_BIT  = 9'(FRAME_W - 1);
    localparam logic [8:0] LAST_SEND = 9'(BLOCK_W - 1);

    state_t              cur;
    state_t              nxt;
    logic [8:0]          bit_cnt;
    logic [8:0]          aux_cnt;
    logic [FRAME_W-1:0]  rx_q;
    logic [BLOCK_W-1:0]  tx_q;
    logic                rx_load;
    logic                rx_shift;
    logic                tx_load;
    logic                tx_shift;
    logic                timeout;
    logic                unused_tx;

    assign rx_load  = cs && (cur == ST_IDLE);
    assign rx_shift = cs && (cur == ST_RECV);
    assign tx_load  = cs && (cur == ST_WAIT_CORE) && core_done;
    assign tx_shift = cs && (cur == ST_SEND);

    spi_shift_reg #(.WIDTH(FRAME_W)) u_rx (
        .clk_master (clk_master),
        .rst        (rst),
        .load       (rx_load),
        .load_val   ({{(FRAME_W-1){1'b0}}, sdi}),
        .shift      (rx_shift),
        .sin        (sdi),
        .q          (rx_q)
    );

    spi_shift_reg #(.WIDTH(BLOCK_W)) u_tx (
        .clk_master (clk_master),
        .rst        (rst),
        .load       (tx_load),
        .load_val   (core_result),
        .shift      (tx_shift),
        .sin        (1'b0),
        .q          (tx_q)
    );

    // The receive register is not touched between the last bit and the next
    // frame start, so it doubles as the stable core_data/core_key holding register.
    assign core_data = rx_q[FRAME_W-1:KEY_W];
    assign core_key  = rx_q[KEY_W-1:0];
    assign unused_tx = ^tx_q[BLOCK_W-2:0];

`ifdef SPI_SLAVE_TIMEOUT_EN
    localparam logic [8:0] LAST_WAIT = 9'(TIMEOUT_CYC - 1);

    assign timeout = (cur == ST_WAIT_CORE) && !core_done && (aux_cnt == LAST_WAIT);

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (rx_load) begin
            err <= 1'b0;
        end else if (cs && timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            cur <= ST_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        if (!cs) begin
            nxt = ST_IDLE;
        end else begin
            case (cur)
                ST_IDLE:      nxt = ST_RECV;
                ST_RECV:      if (bit_cnt == LAST_BIT) nxt = ST_START;
                ST_START:     nxt = ST_WAIT_CORE;
                ST_WAIT_CORE: begin
                    if (core_done) begin
                        nxt = ST_SEND;
                    end else if (timeout) begin
                        nxt = ST_HOLD;
                    end
                end
                ST_SEND:      if (aux_cnt == LAST_SEND) nxt = ST_HOLD;
                ST_HOLD:      nxt = ST_HOLD;
                default:      nxt = ST_IDLE;
            endcase
        end
    end

    // err is only ever set by a timeout, so HOLD with err high is the timeout exit.
    always_comb begin
        core_start = 1'b0;
        frame_done = 1'b0;
        sdo        = 1'b0;
        state      = cur;
        core_start = (cur == ST_START);
        frame_done = (cur == ST_HOLD) && !err;
        sdo        = (cur == ST_SEND) && tx_q[BLOCK_W-1];
    end

    // bit_cnt tracks received bits; aux_cnt times WAIT_CORE and then counts sent bits.
    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            aux_cnt <= '0;
        end else if (!cs) begin
            bit_cnt <= '0;
            aux_cnt <= '0;
        end else begin
            case (cur)
                ST_IDLE:      bit_cnt <= 9'd1;
                ST_RECV:      bit_cnt <= bit_cnt + 9'd1;
                ST_START:     aux_cnt <= '0;
                ST_WAIT_CORE: aux_cnt <= core_done ? 9'd0 : aux_cnt + 9'd1;
                ST_SEND:      aux_cnt <= aux_cnt + 9'd1;
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: table of frames with a core model and result
// scoreboard, plus abort, collision, reset-in-SEND, timeout and NK=8 sequences.
module tb_spi_slave_shifter;
    import spi_aes_pkg::*;

    logic         clk_master = 1'b0;
    logic         rst;
    logic         cs, sdi, core_done;
    logic [127:0] core_result;
    logic         sdo, core_start, frame_done, err;
    logic [127:0] core_data, core_key;
    logic [2:0]   state;

    logic         cs8, sdi8;
    logic         sdo8, core_start8, frame_done8, err8;
    logic [127:0] core_data8;
    logic [255:0] core_key8;
    logic [2:0]   state8;

    always #5 clk_master = ~clk_master;

    spi_slave_shifter #(.NK(4)) dut (
        .clk_master (clk_master), .rst (rst), .cs (cs), .sdi (sdi), .sdo (sdo),
        .core_data (core_data), .core_key (core_key), .core_start (core_start),
        .core_done (core_done), .core_result (core_result),
        .frame_done (frame_done), .err (err), .state (state)
    );

    spi_slave_shifter #(.NK(8)) dut8 (
        .clk_master (clk_master), .rst (rst), .cs (cs8), .sdi (sdi8), .sdo (sdo8),
        .core_data (core_data8), .core_key (core_key8), .core_start (core_start8),
        .core_done (1'b0), .core_result (128'h0),
        .frame_done (frame_done8), .err (err8), .state (state8)
    );

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] result;
        int           lat;
    } vec_t;

    vec_t         vecs[4];
    logic [127:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           start_cnt = 0;

    always @(negedge clk_master) if (core_start) start_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_master);
        #1;
    endtask

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bits(input logic [255:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            cs  = 1'b1;
            sdi = bits[n-1-i];
            tick();
        end
        sdi = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int           s0;
        logic [127:0] got;
        s0 = start_cnt;
        drive_bits({v.data, v.key}, 256);
        check({tag, ".start_hi"}, core_start, 1);
        check({tag, ".core_data"}, core_data, v.data);
        check({tag, ".core_key"}, core_key, v.key);
        tick();
        check({tag, ".start_lo"}, core_start, 0);
        check({tag, ".wait_state"}, state, 3'(ST_WAIT_CORE));
        repeat (v.lat - 1) tick();
        core_done   = 1'b1;
        core_result = v.result;
        exp_q.push_back(v.result);
        tick();
        core_done   = 1'b0;
        core_result = '0;
        got = '0;
        for (int i = 0; i < 128; i++) begin
            got = {got[126:0], sdo};
            tick();
        end
        check({tag, ".sdo_word"}, got, exp_q.pop_front());
        check({tag, ".frame_done"}, frame_done, 1);
        check({tag, ".hold_sdo"}, sdo, 0);
        check({tag, ".hold_state"}, state, 3'(ST_HOLD));
        check({tag, ".start_pulses"}, start_cnt, s0 + 1);
        cs = 1'b0;
        tick();
        check({tag, ".idle_state"}, state, 3'(ST_IDLE));
        check({tag, ".idle_done"}, frame_done, 0);
    endtask

    initial begin
        logic [255:0] key8;
        logic [127:0] data8;
        int           s0;

        rst = 1'b1; cs = 1'b0; sdi = 1'b0; core_done = 1'b0; core_result = '0;
        cs8 = 1'b0; sdi8 = 1'b0;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 12};
        vecs[1] = '{{128{1'b1}}, 128'h0, {64{2'b10}}, 1};
        vecs[2] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(2, 40))};
        vecs[3] = '{128'h0, {128{1'b1}}, 128'h80000000000000000000000000000001, 30};

        repeat (2) tick();
        check("rst.sdo", sdo, 0);
        check("rst.core_start", core_start, 0);
        check("rst.frame_done", frame_done, 0);
        check("rst.err", err, 0);
        check("rst.core_data", core_data, 0);
        check("rst.core_key", core_key, 0);
        check("rst.state", state, 3'(ST_IDLE));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Abort after bit 100, then a full frame must still decode.
        s0 = start_cnt;
        drive_bits({vecs[1].data, vecs[1].key} >> (256 - 101), 101);
        cs = 1'b0;
        tick();
        check("abort.state", state, 3'(ST_IDLE));
        repeat (5) tick();
        check("abort.no_start", start_cnt, s0);
        run_txn(vecs[2], "post_abort");

        // cs drop and core_done in the same cycle: cs wins, inputs kept.
        s0 = start_cnt;
        drive_bits({vecs[0].data, vecs[0].key}, 256);
        tick();
        cs = 1'b0; core_done = 1'b1; core_result = vecs[0].result;
        tick();
        core_done = 1'b0; core_result = '0;
        check("collide.state", state, 3'(ST_IDLE));
        check("collide.sdo", sdo, 0);
        check("collide.data_kept", core_data, vecs[0].data);
        check("collide.key_kept", core_key, vecs[0].key);
        tick();
        check("collide.still_idle", state, 3'(ST_IDLE));
        check("collide.one_start", start_cnt, s0 + 1);

        // Asynchronous reset in the middle of SEND.
        drive_bits({vecs[0].data, vecs[0].key}, 256);
        tick();
        core_done = 1'b1; core_result = vecs[0].result;
        tick();
        core_done = 1'b0; core_result = '0;
        repeat (10) tick();
        check("rst_send.state_before", state, 3'(ST_SEND));
        check("rst_send.bit117", sdo, vecs[0].result[117]);
        #2 rst = 1'b1;
        #1;
        check("rst_send.sdo", sdo, 0);
        check("rst_send.frame_done", frame_done, 0);
        check("rst_send.state", state, 3'(ST_IDLE));
        check("rst_send.data_clr", core_data, 0);
        @(negedge clk_master);
        rst = 1'b0; cs = 1'b0;
        tick();
        run_txn(vecs[0], "after_rst");

        // Core never answers.
        drive_bits({vecs[3].data, vecs[3].key}, 256);
        tick();
        repeat (255) tick();
        check("tmo.last_wait", state, 3'(ST_WAIT_CORE));
        check("tmo.err_early", err, 0);
        tick();
`ifdef SPI_SLAVE_TIMEOUT_EN
        check("tmo.err", err, 1);
        check("tmo.state", state, 3'(ST_HOLD));
        check("tmo.frame_done", frame_done, 0);
        core_done = 1'b1; core_result = vecs[3].result;
        tick();
        core_done = 1'b0; core_result = '0;
        check("tmo.done_ignored", state, 3'(ST_HOLD));
        check("tmo.hold_sdo", sdo, 0);
        cs = 1'b0;
        tick();
        check("tmo.err_sticky", err, 1);
`else
        check("tmo.err", err, 0);
        check("tmo.state", state, 3'(ST_WAIT_CORE));
        cs = 1'b0;
        tick();
`endif
        check("tmo.idle", state, 3'(ST_IDLE));
        cs = 1'b1; sdi = 1'b0;
        tick();
        check("tmo.err_cleared", err, 0);
        cs = 1'b0;
        tick();

        // NK=8: 384-bit frame, last 256 bits are the key.
        data8 = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) key8[i*32 +: 32] = $urandom;
        for (int i = 0; i < 128; i++) begin
            cs8 = 1'b1; sdi8 = data8[127-i];
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            sdi8 = key8[255-i];
            tick();
        end
        check("nk8.start", core_start8, 1);
        check("nk8.core_data", core_data8, data8);
        check("nk8.core_key", core_key8, key8);
        check("nk8.err", err8, 0);
        cs8 = 1'b0; sdi8 = 1'b0;
        tick();
        check("nk8.idle", state8, 3'(ST_IDLE));
        check("nk8.sdo", sdo8, 0);
        check("nk8.frame_done", frame_done8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
